// File: rtl/sector_cache_arbiter.sv
// Shares one port of the sector cache RAM between the drive serializer (0) and the
// storage loader (1) as whole-sector bursts, and tracks the held sector's tag/valid/dirty.
module sector_cache_arbiter #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned TAG_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          req,
  input  logic [1:0]          req_wr,
  input  logic [2*TAG_W-1:0]  req_tag,
  output logic [1:0]          grant,
  input  logic [2*DATA_W-1:0] wdata,
  input  logic [1:0]          wvalid,
  output logic [1:0]          wready,
  input  logic [1:0]          rstrobe,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rvalid,
  output logic [1:0]          done,
  input  logic                invalidate,
  output logic [TAG_W-1:0]    cache_tag,
  output logic                cache_valid,
  output logic                cache_dirty,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_din,
  output logic                ram_wr_en,
  input  logic [DATA_W-1:0]   ram_dout
);

  typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                last_grant_q, last_grant_d;
  logic                wr_dir_q, wr_dir_d;
  logic [1:0]          grant_d, done_d, rv_q, rv_d;
  logic [TAG_W-1:0]    tag_d;
  logic                valid_d, dirty_d;
  logic                owner, arb;
  logic                own_req, own_wvalid, own_strobe;
  logic [DATA_W-1:0]   own_wdata;
  logic [TAG_W-1:0]    own_tag;

  // Grant is held through DONE, so its upper bit names the current owner.
  assign owner      = grant[1];
  assign own_req    = req[owner];
  assign own_wvalid = wvalid[owner];
  assign own_strobe = rstrobe[owner];
  assign own_wdata  = owner ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  assign own_tag    = owner ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
  assign arb        = (req == 2'b11) ? ~last_grant_q : req[1];

  // RAM data has one cycle of latency, so the byte is passed straight through;
  // gating with req drops a byte still in flight when the owner aborts.
  assign rvalid = rv_q & req;
  assign rdata  = (|rvalid) ? ram_dout : '0;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    last_grant_d = last_grant_q;
    wr_dir_d     = wr_dir_q;
    grant_d      = grant;
    done_d       = '0;
    rv_d         = '0;
    tag_d        = cache_tag;
    valid_d      = cache_valid;
    dirty_d      = cache_dirty;
    wready       = '0;
    ram_addr     = ptr_q;
    ram_din      = '0;
    ram_wr_en    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d      = arb ? 2'b10 : 2'b01;
          last_grant_d = arb;
          wr_dir_d     = req_wr[arb];
          ptr_d        = '0;
          state_d      = req_wr[arb] ? WRITE : READ;
        end
      end
      WRITE: begin
        if (!own_req) begin
          // A partial overwrite leaves the sector incomplete.
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = '0;
          valid_d = 1'b0;
        end else begin
          wready = grant;
          if (own_wvalid) begin
            ram_wr_en = 1'b1;
            ram_din   = own_wdata;
            ptr_d     = ptr_q + ADDR_W'(1);
            if (ptr_q == LAST_ADDR) begin
              ptr_d   = '0;
              state_d = DONE;
              done_d  = grant;
            end
          end
        end
      end
      READ: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = '0;
        end else if (own_strobe) begin
          rv_d  = grant;
          ptr_d = ptr_q + ADDR_W'(1);
          if (ptr_q == LAST_ADDR) begin
            ptr_d   = '0;
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!own_req) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = '0;
        end else begin
          state_d = DONE;
          done_d  = grant;
        end
      end
      DONE: begin
        state_d = IDLE;
        grant_d = '0;
        if (wr_dir_q) begin
          tag_d   = own_tag;
          valid_d = 1'b1;
          dirty_d = ~owner;
        end else if (owner) begin
          dirty_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (invalidate) begin
      valid_d = 1'b0;
      dirty_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      last_grant_q <= 1'b1;
      wr_dir_q     <= 1'b0;
      grant        <= '0;
      done         <= '0;
      rv_q         <= '0;
      cache_tag    <= '0;
      cache_valid  <= 1'b0;
      cache_dirty  <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      last_grant_q <= last_grant_d;
      wr_dir_q     <= wr_dir_d;
      grant        <= grant_d;
      done         <= done_d;
      rv_q         <= rv_d;
      cache_tag    <= tag_d;
      cache_valid  <= valid_d;
      cache_dirty  <= dirty_d;
    end
  end

endmodule
